imem_wait_responder: RTL and testbench
======================================

IMEM_WAIT_RESPONDER -- requirements
Module: imem_wait_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning idle cycles inserted before each fetch is served (legal range 0..15).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit instruction words stored.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-005 Port imem_addr  input  32  byte fetch address driven by the pipeline.
REQ-006 Port imem_data  output  32  registered instruction word for the served address.
REQ-007 Port imem_ready  output  1  imem_data is valid for the current imem_addr.
REQ-008 Port prog_we  input  1  program-load write strobe.
REQ-009 Port prog_addr  input  32  byte address of the program-load write.
REQ-010 Port prog_wdata  input  32  program-load write data.
REQ-011 Port fetch_count  output  32  number of fetches completed since reset.
REQ-012 Port stall_count  output  32  number of cycles with imem_ready==0 since reset.

Function
REQ-013 Word index SHALL be imem_addr[31:2] truncated modulo DEPTH; imem_addr[1:0] are ignored; the same rule applies to prog_addr.
REQ-014 FSM states SHALL be IDLE, WAIT, SERVE; IDLE is entered only by reset and exits to WAIT on the first clock edge after reset deasserts.
REQ-015 On entering WAIT the block SHALL capture imem_addr as pend_addr and load the wait counter with WAIT_CYCLES.
REQ-016 In WAIT the counter SHALL decrement once per cycle; when it is 0, the next edge SHALL latch mem[pend_addr] into imem_data, set served_addr=pend_addr, increment fetch_count, and enter SERVE.
REQ-017 Fetch latency from a new address SHALL be exactly WAIT_CYCLES+1 rising edges until imem_ready is high (1 edge when WAIT_CYCLES=0).
REQ-018 imem_ready SHALL equal (state==SERVE) AND (imem_addr[31:2]==served_addr[31:2]), and SHALL never be high with data belonging to a different word.
REQ-019 In SERVE, a word-address change SHALL transition to WAIT on the next edge with the new address captured; imem_ready drops combinationally in the same cycle the address changes.
REQ-020 In WAIT, a word-address change relative to pend_addr SHALL restart the access: recapture address, reload counter; fetch_count unchanged.
REQ-021 prog_we SHALL write mem[prog_addr] at the rising edge, with no effect on counters.
REQ-022 A prog_we to the word equal to served_addr (in SERVE) or pend_addr (in WAIT) SHALL force WAIT with counter reloaded, so stale data is never served.
REQ-023 stall_count SHALL increment every cycle after reset release in which imem_ready==0; both counters wrap modulo 2^32.
REQ-024 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-025 While reset==0: state=IDLE, imem_data=0, imem_ready=0, fetch_count=0, stall_count=0, wait counter=0, pend_addr=served_addr=0, applied asynchronously.
REQ-026 Reset asserted mid-WAIT or mid-SERVE SHALL abandon the access immediately; no fetch is counted.

Structure
REQ-027 Package mips32_mem_pkg SHALL hold the FSM state enum, WORD_W=32 and the counter width constant.
REQ-028 Storage SHALL be one sub-module, imem_storage (DEPTH x 32, synchronous write, asynchronous read); FSM and counters in the top.

Verification
REQ-029 WAIT_CYCLES=2, mem[0]=0x20080005, addr 0 held after reset release -> imem_ready rises after 3 edges, imem_data=0x20080005, fetch_count=1.
REQ-030 In SERVE at addr 0, switch to addr 4 (mem[1]=0x200A0000) -> imem_ready 0 same cycle, high 3 edges later with 0x200A0000, stall_count increased by 3.
REQ-031 During WAIT for addr 8, change to addr 12 after 1 edge -> ready only 3 edges after the change with mem[3]; fetch_count +1 only.
REQ-032 In SERVE at addr 4, prog_we to addr 4 with 0xDEADBEEF -> ready drops, returns after 3 edges with 0xDEADBEEF.
REQ-033 WAIT_CYCLES=0, addr 1020 then 1024 (DEPTH=256) -> each served 1 edge later; 1024 returns mem[0].
REQ-034 Assert reset mid-WAIT -> imem_ready=0, counters=0 immediately; memory contents preserved on re-fetch.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package mips32_mem_pkg;

  localparam int WORD_W = 32;  // instruction word / address width
  localparam int CNT_W  = 32;  // fetch and stall counter width
  localparam int WCNT_W = 4;   // wait counter width, covers WAIT_CYCLES 0..15

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_wait_responder_if.sv
// Fetch bus between the pipeline (master) and the instruction memory (slave).
interface imem_wait_responder_if;
  import mips32_mem_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_data;
  logic              imem_ready;

  modport master (output imem_addr, input imem_data, input imem_ready);
  modport slave  (input imem_addr, output imem_data, output imem_ready);
endinterface

// File: rtl/imem_storage.sv
// DEPTH x 32 word store: synchronous write, asynchronous read, never reset.
module imem_storage
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // program-load write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_wait_responder.sv
// Instruction memory that inserts WAIT_CYCLES idle cycles before serving each
// new word address, with fetch/stall statistics. DEPTH must be a power of two
// so that truncating the word index implements the modulo-DEPTH wrap.
module imem_wait_responder
  import mips32_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_wait_responder_if.slave  bus,
  input  logic                  prog_we,
  input  logic [WORD_W-1:0]     prog_addr,
  input  logic [WORD_W-1:0]     prog_wdata,
  output logic [CNT_W-1:0]      fetch_count,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  imem_state_e         state;
  logic [WORD_W-1:0]   pend_addr;
  logic [WORD_W-1:0]   served_addr;
  logic [WORD_W-1:0]   data_q;
  logic [WCNT_W-1:0]   wcnt;
  logic [WORD_W-1:0]   rd_word;

  logic [IDX_W-1:0]    addr_idx, prog_idx, pend_idx, served_idx;
  logic                chg_pend, chg_served;
  logic                hit_new, hit_pend, hit_served;
  logic                ready;
  logic                do_launch, do_serve;
  logic                unused_bits;

  assign addr_idx   = bus.imem_addr[2 +: IDX_W];
  assign prog_idx   = prog_addr[2 +: IDX_W];
  assign pend_idx   = pend_addr[2 +: IDX_W];
  assign served_idx = served_addr[2 +: IDX_W];

  assign chg_pend   = bus.imem_addr[WORD_W-1:2] != pend_addr[WORD_W-1:2];
  assign chg_served = bus.imem_addr[WORD_W-1:2] != served_addr[WORD_W-1:2];

  // Writes are matched on the aliased index since that is the word that changes.
  assign hit_new    = prog_we && (prog_idx == addr_idx);
  assign hit_pend   = prog_we && (prog_idx == pend_idx);
  assign hit_served = prog_we && (prog_idx == served_idx);

  // Ready is combinational so it drops in the very cycle the address moves.
  assign ready          = (state == SERVE) && !chg_served;
  assign bus.imem_ready = ready;
  assign bus.imem_data  = data_q;

  assign unused_bits = ^{prog_addr[1:0], bus.imem_addr[1:0], served_addr[1:0]};

  // One read port at the live address suffices: a WAIT only completes while
  // the live word equals pend_addr, so mem[addr_idx] == mem[pend_idx] then.
  imem_storage #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_storage (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_idx),
    .wdata (prog_wdata),
    .raddr (addr_idx),
    .rdata (rd_word)
  );

  // Decide whether this edge starts a new access and/or completes one.
  // The capturing edge counts as the first wait edge, so a completed WAIT
  // exits when the counter reaches 1 (or 0 after a forced reload with
  // WAIT_CYCLES==0); with WAIT_CYCLES==0 the capturing edge itself serves,
  // unless that same edge writes the word being fetched.
  always_comb begin
    do_launch = 1'b0;
    do_serve  = 1'b0;
    case (state)
      IDLE:    do_launch = 1'b1;
      WAIT: begin
        if (chg_pend || hit_pend)         do_launch = 1'b1;
        else if (wcnt <= WCNT_W'(1))      do_serve  = 1'b1;
      end
      SERVE:   if (chg_served || hit_served) do_launch = 1'b1;
      default: do_launch = 1'b0;
    endcase
    if (do_launch && (WAIT_CYCLES == 0) && !hit_new) do_serve = 1'b1;
  end

  // FSM, registered data and statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pend_addr   <= '0;
      served_addr <= '0;
      data_q      <= '0;
      wcnt        <= '0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!ready) stall_count <= stall_count + CNT_W'(1);
      if (do_launch) pend_addr <= bus.imem_addr;
      if (do_serve) begin
        state       <= SERVE;
        data_q      <= rd_word;
        served_addr <= do_launch ? bus.imem_addr : pend_addr;
        fetch_count <= fetch_count + CNT_W'(1);
      end else if (do_launch) begin
        state <= WAIT;
        wcnt  <= WAIT_LD;
      end else if (state == WAIT) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_wait_responder.sv
// Scoreboard bench: one responder with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_imem_wait_responder;
  import mips32_mem_pkg::*;

  logic              clk;
  logic              reset;
  logic              prog_we;
  logic [WORD_W-1:0] prog_addr, prog_wdata;
  logic [CNT_W-1:0]  fetch2, stall2, fetch0, stall0;

  imem_wait_responder_if bus2 ();
  imem_wait_responder_if bus0 ();

  imem_wait_responder #(.WAIT_CYCLES(2), .DEPTH(256)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .fetch_count(fetch2), .stall_count(stall2)
  );

  imem_wait_responder #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .fetch_count(fetch0), .stall_count(stall0)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Count edges until ready (bounded); the caller already pushed the expected word.
  task automatic wait_rdy(input bit sel0, input int start, output int n);
    n = start;
    while (!(sel0 ? bus0.imem_ready : bus2.imem_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  // Move the W=2 responder to a new word and check ready drop, latency and data.
  task automatic fetch_w2(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input int lat);
    int n;
    exp_q.push_back(exp);
    bus2.imem_addr = addr;
    #1 chk({tag, "_drop"}, 32'(bus2.imem_ready), 32'd0);
    wait_rdy(1'b0, 0, n);
    chk({tag, "_lat"}, n, lat);
    pop_chk({tag, "_data"}, bus2.imem_data);
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] s0;
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    bus2.imem_addr = 32'd0;
    bus0.imem_addr = 32'd1020;
    #1;
    chk("rst_ready", 32'(bus2.imem_ready), 32'd0);
    chk("rst_data", bus2.imem_data, 32'd0);
    chk("rst_fetch", fetch2, 32'd0);
    chk("rst_stall", stall2, 32'd0);

    // memory loads while reset is held; storage ignores reset
    @(negedge clk);
    prog(32'd0,    32'h2008_0005);
    prog(32'd4,    32'h200A_0000);
    prog(32'd8,    32'h1111_1111);
    prog(32'd12,   32'h3333_3333);
    prog(32'd1020, 32'hFFFF_00FF);
    chk("rst_hold_stall", stall2, 32'd0);

    // release and fetch addr 0 (W=2) / addr 1020 (W=0)
    reset = 1'b1;
    exp_q.push_back(32'h2008_0005);
    @(negedge clk);
    chk("w0_first_lat1", 32'(bus0.imem_ready), 32'd1);
    chk("w0_first_data", bus0.imem_data, 32'hFFFF_00FF);
    wait_rdy(1'b0, 1, n);
    chk("first_lat", n, 3);
    pop_chk("first_data", bus2.imem_data);
    chk("first_fetch", fetch2, 32'd1);
    chk("first_stall", stall2, 32'd3);

    // sequential fetch to the next word
    s0 = stall2;
    fetch_w2("a4", 32'd4, 32'h200A_0000, 3);
    chk("a4_stall", stall2, s0 + 32'd3);
    chk("a4_fetch", fetch2, 32'd2);

    // restart mid-WAIT: 8 then 12 after one edge
    bus2.imem_addr = 32'd8;
    @(negedge clk);
    chk("restart_busy", 32'(bus2.imem_ready), 32'd0);
    exp_q.push_back(32'h3333_3333);
    bus2.imem_addr = 32'd12;
    #1;
    wait_rdy(1'b0, 0, n);
    chk("restart_lat", n, 3);
    pop_chk("restart_data", bus2.imem_data);
    chk("restart_fetch", fetch2, 32'd3);

    // byte offset within the served word must keep ready high
    bus2.imem_addr = 32'd14;
    #1 chk("byte_off_ready", 32'(bus2.imem_ready), 32'd1);
    @(negedge clk);

    // program writes while serving addr 4
    fetch_w2("a4b", 32'd4, 32'h200A_0000, 3);
    prog(32'd40, 32'h8888_8888);
    chk("miss_wr_ready", 32'(bus2.imem_ready), 32'd1);
    chk("miss_wr_fetch", fetch2, 32'd4);
    exp_q.push_back(32'hDEAD_BEEF);
    prog(32'd4, 32'hDEAD_BEEF);
    chk("hit_wr_drop", 32'(bus2.imem_ready), 32'd0);
    wait_rdy(1'b0, 1, n);
    chk("hit_wr_lat", n, 3);
    pop_chk("hit_wr_data", bus2.imem_data);
    chk("hit_wr_fetch", fetch2, 32'd5);

    // W=0: 1020 -> 1024 wraps to word 0, served on the next edge
    exp_q.push_back(32'h2008_0005);
    bus0.imem_addr = 32'd1024;
    #1 chk("w0_wrap_drop", 32'(bus0.imem_ready), 32'd0);
    wait_rdy(1'b1, 0, n);
    chk("w0_wrap_lat", n, 1);
    pop_chk("w0_wrap_data", bus0.imem_data);
    chk("w0_fetch", fetch0, 32'd2);

    // W=0 write hit on the served word: reload forces one wait edge
    exp_q.push_back(32'h0BAD_F00D);
    prog(32'd0, 32'h0BAD_F00D);
    chk("w0_hit_drop", 32'(bus0.imem_ready), 32'd0);
    wait_rdy(1'b1, 1, n);
    chk("w0_hit_lat", n, 2);
    pop_chk("w0_hit_data", bus0.imem_data);

    // reset asserted mid-WAIT abandons the access
    bus2.imem_addr = 32'd8;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus2.imem_ready), 32'd0);
    chk("midrst_fetch", fetch2, 32'd0);
    chk("midrst_stall", stall2, 32'd0);
    chk("midrst_data", bus2.imem_data, 32'd0);
    chk("midrst_fetch0", fetch0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h1111_1111);
    wait_rdy(1'b0, 0, n);
    chk("refetch_lat", n, 3);
    pop_chk("refetch_data", bus2.imem_data);
    chk("refetch_fetch", fetch2, 32'd1);
    fetch_w2("kept", 32'd4, 32'hDEAD_BEEF, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
